sound_scheduler: RTL and testbench
==================================

# sound_scheduler

Queues and sequences the single-cycle game sound events (failure, success, eat, tick) in front of the `sound` generator. It ensures that a new event never silently truncates a more important sound and that back-to-back eats are all heard. Each event is forwarded as a single-cycle pulse once the previously issued sound's frame-counted play time has elapsed. The block sits between the game logic and `sound`, sharing its `vsync_pulse`.

## Interface
Parameters:
- DUR_FAIL, default 25: frames a failure sound occupies the generator (1..31).
- DUR_SUCC, default 25: frames for success (1..31).
- DUR_EAT, default 25: frames for eat (1..31).
- DUR_TICK, default 2: frames for tick (1..31).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- vsync_pulse  in  1  frame pulse level; the rising edge is detected internally with a registered previous value.
- mute  in  1  level; when high, all events are discarded.
- failure, success, eat, tick  in  1 each  single-cycle event requests.
- snd_failure, snd_success, snd_eat, snd_tick  out  1 each  registered single-cycle pulses to `sound`.
- busy  out  1  high while in PLAY.

## Operation
State:
- FSM with two states, IDLE and PLAY.
- cur: 2-bit class currently playing (0 tick, 1 eat, 2 success, 3 failure).
- timer: 5-bit.
- pend_fail, pend_succ: 1-bit flags.
- eat_cnt: 2-bit counter, saturating at 3.
- pend_tick: 1-bit flag.
- prev_vsync: register for edge detection.

Capture, every cycle, before dispatch:
- failure sets pend_fail, clears eat_cnt, pend_tick and pend_succ.
- success sets pend_succ; duplicate requests merge.
- eat increments eat_cnt, saturating at 3; further eats are dropped.
- tick sets pend_tick only if the FSM is IDLE and no other event is pending or arriving in the same cycle. Otherwise the tick is dropped, because stale ticks are meaningless.

Dispatch:
- Priority is failure > success > eat > tick.
- In IDLE, if anything is pending (including requests captured this cycle):
  - pulse the corresponding snd_* output in the next cycle;
  - clear the flag, or decrement eat_cnt;
  - load timer with the matching DUR;
  - set cur;
  - go to PLAY.
- In PLAY:
  - each vsync rising edge decrements timer;
  - when the decrement takes timer from 1 to 0, go to IDLE in that same clock;
  - dispatch is possible on the following cycle.
- Preemption: in PLAY with cur ≤ 1 (tick or eat), a pending failure or success dispatches immediately. The interrupted sound is not requeued. success never preempts success or failure; failure never preempts failure.

Mute:
- While mute is high, all pending state is cleared every cycle.
- snd_* stay 0.
- The FSM is forced to IDLE and timer to 0.

Reset sets all registers and outputs to 0, state IDLE. Reset mid-PLAY aborts the sound and loses queued events. An event coincident with reset is lost.

## Timing
- Latency: a request at cycle N while IDLE and empty gives snd_* high during cycle N+1 only.
- snd_* outputs are one-hot: at most one pulse per cycle, and at most one dispatch per 2 cycles.
- busy rises in the same cycle as the dispatch pulse. It falls the cycle after the vsync edge that zeroes timer.
- A vsync edge coincident with a dispatch is ignored for the new timer; counting starts with the next edge.
- Simultaneous failure+success+eat+tick in one IDLE cycle:
  - snd_failure pulses;
  - success and eat are cleared by the failure;
  - tick is dropped.
- eat_cnt at 3 plus a new eat in the same cycle as a dispatch decrement gives 3 (decrement, then increment, saturate).

## Test plan
- Reset, then a single eat at cycle 10 → snd_eat high at cycle 11 only; busy high; busy low one cycle after the 25th vsync edge.
- Four eats during one PLAY of eat → three further snd_eat pulses, each 25 frames apart; the fourth eat is dropped.
- Tick while an eat is playing → no snd_tick ever; tick while IDLE → snd_tick, and busy lasts 2 frames.
- Eat playing, then success arrives → snd_success the next cycle, and the eat is not replayed. success then failure → failure waits for success to finish.
- failure, eat and tick in the same cycle → only snd_failure, with no later eat or tick pulses.
- mute asserted mid-PLAY with eat_cnt=2 → busy low the next cycle, no pulses. After mute releases, a new eat → snd_eat after 1 cycle.

Source files
------------

// File: rtl/sound_scheduler.sv
// Event scheduler in front of the sound generator: queues failure/success/eat/tick
// requests and forwards them one at a time, each occupying a frame-counted slot.
module sound_scheduler #(
    parameter int DUR_FAIL = 25,
    parameter int DUR_SUCC = 25,
    parameter int DUR_EAT  = 25,
    parameter int DUR_TICK = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic vsync_pulse,
    input  logic mute,
    input  logic failure,
    input  logic success,
    input  logic eat,
    input  logic tick,
    output logic snd_failure,
    output logic snd_success,
    output logic snd_eat,
    output logic snd_tick,
    output logic busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PLAY = 1'b1;

    localparam logic [1:0] C_TICK = 2'd0;
    localparam logic [1:0] C_EAT  = 2'd1;
    localparam logic [1:0] C_SUCC = 2'd2;
    localparam logic [1:0] C_FAIL = 2'd3;

    logic [0:0] state_reg, state_next;
    logic [1:0] cur_reg, cur_next;
    logic [4:0] timer_reg, timer_next;
    logic       pend_fail_reg, pend_fail_next;
    logic       pend_succ_reg, pend_succ_next;
    logic       pend_tick_reg, pend_tick_next;
    logic [1:0] eat_cnt_reg, eat_cnt_next;
    logic       prev_vsync_reg;
    logic [3:0] snd_reg, snd_next;

    logic       vs_edge;
    logic       idle;
    logic       pf_c, ps_c, pt_c;
    logic [2:0] eat_sum, eat_left;
    logic       others_any;
    logic       any_pend;
    logic [1:0] sel;
    logic       preempt_ok;
    logic       dispatch;
    logic [4:0] dur_sel;

    assign vs_edge = vsync_pulse & ~prev_vsync_reg;
    assign idle    = (state_reg == ST_IDLE);

    // Requests of this cycle are merged with the queue before dispatch looks at it.
    assign pf_c       = pend_fail_reg | failure;
    assign ps_c       = ~failure & (pend_succ_reg | success);
    assign eat_sum    = failure ? 3'd0 : ({1'b0, eat_cnt_reg} + {2'b00, eat});
    assign others_any = pend_fail_reg | pend_succ_reg | (eat_cnt_reg != 2'd0)
                      | failure | success | eat;
    assign pt_c       = ~failure & (pend_tick_reg | (tick & idle & ~others_any));
    assign any_pend   = pf_c | ps_c | (eat_sum != 3'd0) | pt_c;

    always_comb begin
        sel = C_TICK;
        if (pf_c) begin
            sel = C_FAIL;
        end else if (ps_c) begin
            sel = C_SUCC;
        end else if (eat_sum != 3'd0) begin
            sel = C_EAT;
        end
    end

    always_comb begin
        dur_sel = 5'(DUR_TICK);
        case (sel)
            C_FAIL:  dur_sel = 5'(DUR_FAIL);
            C_SUCC:  dur_sel = 5'(DUR_SUCC);
            C_EAT:   dur_sel = 5'(DUR_EAT);
            default: dur_sel = 5'(DUR_TICK);
        endcase
    end

    // Only tick/eat can be interrupted; holding off while a pulse is out keeps pulses 2 cycles apart.
    assign preempt_ok = ~idle & ~cur_reg[1] & (pf_c | ps_c) & ~(|snd_reg);
    assign dispatch   = ~mute & ((idle & any_pend) | preempt_ok);

    assign eat_left = eat_sum - {2'b00, (dispatch && (sel == C_EAT))};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_snd
            assign snd_next[gi] = dispatch && (sel == 2'(gi));
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        cur_next       = cur_reg;
        timer_next     = timer_reg;
        pend_fail_next = pf_c & ~(dispatch && (sel == C_FAIL));
        pend_succ_next = ps_c & ~(dispatch && (sel == C_SUCC));
        pend_tick_next = pt_c & ~(dispatch && (sel == C_TICK));
        eat_cnt_next   = (eat_left > 3'd3) ? 2'd3 : eat_left[1:0];
        if (mute) begin
            state_next     = ST_IDLE;
            timer_next     = 5'd0;
            pend_fail_next = 1'b0;
            pend_succ_next = 1'b0;
            pend_tick_next = 1'b0;
            eat_cnt_next   = 2'd0;
        end else if (dispatch) begin
            state_next = ST_PLAY;
            timer_next = dur_sel;
            cur_next   = sel;
        end else if (!idle && vs_edge) begin
            if (timer_reg <= 5'd1) begin
                state_next = ST_IDLE;
                timer_next = 5'd0;
            end else begin
                timer_next = timer_reg - 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cur_reg        <= 2'd0;
            timer_reg      <= 5'd0;
            pend_fail_reg  <= 1'b0;
            pend_succ_reg  <= 1'b0;
            pend_tick_reg  <= 1'b0;
            eat_cnt_reg    <= 2'd0;
            prev_vsync_reg <= 1'b0;
            snd_reg        <= 4'd0;
        end else begin
            state_reg      <= state_next;
            cur_reg        <= cur_next;
            timer_reg      <= timer_next;
            pend_fail_reg  <= pend_fail_next;
            pend_succ_reg  <= pend_succ_next;
            pend_tick_reg  <= pend_tick_next;
            eat_cnt_reg    <= eat_cnt_next;
            prev_vsync_reg <= vsync_pulse;
            snd_reg        <= snd_next;
        end
    end

    assign snd_tick    = snd_reg[0];
    assign snd_eat     = snd_reg[1];
    assign snd_success = snd_reg[2];
    assign snd_failure = snd_reg[3];
    assign busy        = (state_reg == ST_PLAY);

endmodule

// File: tb/tb_sound_scheduler.sv
// Directed bench for sound_scheduler: inputs change 1 time unit after posedge,
// outputs are observed on the falling edge.
module tb_sound_scheduler;

    logic clk, rst, vsync_pulse, mute, failure, success, eat, tick;
    logic snd_failure, snd_success, snd_eat, snd_tick, busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int vph = 0;

    int cnt_fail = 0, cnt_succ = 0, cnt_eat = 0, cnt_tick = 0;
    int onehot_err = 0, nobusy_err = 0, gap_err = 0;
    int edge_cnt = 0;
    int intervals[$];
    logic prev_pulse = 1'b0, vs_prev = 1'b0, busy_prev = 1'b0;

    sound_scheduler dut (
        .clk(clk), .rst(rst), .vsync_pulse(vsync_pulse), .mute(mute),
        .failure(failure), .success(success), .eat(eat), .tick(tick),
        .snd_failure(snd_failure), .snd_success(snd_success),
        .snd_eat(snd_eat), .snd_tick(snd_tick), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame pulse: high one cycle out of four.
    initial begin
        vsync_pulse = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            vph = (vph + 1) % 4;
            vsync_pulse = (vph == 0);
        end
    end

    // Pulse/busy monitor; records the number of frame edges in each busy interval.
    always @(negedge clk) begin
        logic [3:0] sv;
        logic ve;
        sv = {snd_failure, snd_success, snd_eat, snd_tick};
        if (!rst) begin
            if (sv != 4'd0) begin
                if ($countones(sv) > 1) onehot_err++;
                if (!busy) nobusy_err++;
                if (prev_pulse) gap_err++;
                if (sv[3]) cnt_fail++;
                if (sv[2]) cnt_succ++;
                if (sv[1]) cnt_eat++;
                if (sv[0]) cnt_tick++;
            end
            ve = vsync_pulse && !vs_prev;
            if (busy && !busy_prev) edge_cnt = 0;
            if (busy && ve) edge_cnt++;
            if (!busy && busy_prev) intervals.push_back(edge_cnt);
            busy_prev = busy;
        end
        prev_pulse = (sv != 4'd0);
        vs_prev = vsync_pulse;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle request {failure, success, eat, tick}; returns the request cycle.
    task automatic request(input logic [3:0] ev, output int req_cyc);
        @(posedge clk);
        #1;
        req_cyc = cyc;
        {failure, success, eat, tick} = ev;
        @(posedge clk);
        #1;
        {failure, success, eat, tick} = 4'b0000;
    endtask

    task automatic wait_idle(input string name);
        int low = 0;
        int budget = 3000;
        while (low < 3 && budget > 0) begin
            @(negedge clk);
            low = busy ? 0 : low + 1;
            budget--;
        end
        if (budget == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: timed out waiting for idle, busy=%0b", name, busy);
        end
    endtask

    // Issue a request from idle and check the pulse appears exactly one cycle later.
    task automatic check_latency(input string name, input logic [3:0] ev, input logic [3:0] exp_snd);
        logic [3:0] sv;
        @(posedge clk);
        #1;
        {failure, success, eat, tick} = ev;
        @(negedge clk);
        sv = {snd_failure, snd_success, snd_eat, snd_tick};
        n_cmp++;
        if (sv !== 4'd0) begin
            n_err++;
            $display("FAIL %s_req_cycle: snd=%b want 0000", name, sv);
        end
        @(posedge clk);
        #1;
        {failure, success, eat, tick} = 4'b0000;
        @(negedge clk);
        sv = {snd_failure, snd_success, snd_eat, snd_tick};
        n_cmp++;
        if (sv !== exp_snd || busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s_pulse: snd=%b busy=%b want snd=%b busy=1", name, sv, busy, exp_snd);
        end
        @(negedge clk);
        sv = {snd_failure, snd_success, snd_eat, snd_tick};
        n_cmp++;
        if (sv !== 4'd0) begin
            n_err++;
            $display("FAIL %s_pulse_width: snd=%b want 0000", name, sv);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mute = 1'b0;
        {failure, success, eat, tick} = 4'b0010;
        wait_cycles(3);
        rst = 1'b0;
        {failure, success, eat, tick} = 4'b0000;
        @(negedge clk);
        n_cmp++;
        if ({snd_failure, snd_success, snd_eat, snd_tick, busy} !== 5'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {snd_failure, snd_success, snd_eat, snd_tick, busy});
        end
        wait_cycles(6);
        n_cmp++;
        if (cnt_eat !== 0) begin
            n_err++;
            $display("FAIL reset_event_lost: eat pulses %0d want 0", cnt_eat);
        end
    endtask

    task automatic test_single_eat();
        intervals.delete();
        check_latency("single_eat", 4'b0010, 4'b0010);
        wait_idle("single_eat");
        n_cmp++;
        if (intervals.size() !== 1 || intervals[0] !== 25 || cnt_eat !== 1) begin
            n_err++;
            $display("FAIL single_eat_frames: intervals=%0d first=%0d eats=%0d want 1/25/1",
                     intervals.size(), (intervals.size() > 0) ? intervals[0] : -1, cnt_eat);
        end
    endtask

    task automatic test_four_eats();
        int c;
        int e0;
        int bad;
        e0 = cnt_eat;
        intervals.delete();
        request(4'b0010, c);
        wait_cycles(5);
        for (int i = 0; i < 4; i++) begin
            request(4'b0010, c);
            wait_cycles(2);
        end
        wait_idle("four_eats");
        n_cmp++;
        if (cnt_eat - e0 !== 4) begin
            n_err++;
            $display("FAIL four_eats_count: eat pulses %0d want 4", cnt_eat - e0);
        end
        bad = 0;
        foreach (intervals[i]) if (intervals[i] != 25) bad++;
        n_cmp++;
        if (intervals.size() !== 4 || bad !== 0) begin
            n_err++;
            $display("FAIL four_eats_spacing: intervals=%0d off=%0d want 4/0", intervals.size(), bad);
        end
    endtask

    task automatic test_tick();
        int c;
        int t0;
        t0 = cnt_tick;
        request(4'b0010, c);
        wait_cycles(8);
        request(4'b0001, c);
        wait_idle("tick_during_eat");
        n_cmp++;
        if (cnt_tick - t0 !== 0) begin
            n_err++;
            $display("FAIL tick_dropped: tick pulses %0d want 0", cnt_tick - t0);
        end
        intervals.delete();
        check_latency("tick_idle", 4'b0001, 4'b0001);
        wait_idle("tick_idle");
        n_cmp++;
        if (cnt_tick - t0 !== 1 || intervals.size() !== 1 || intervals[0] !== 2) begin
            n_err++;
            $display("FAIL tick_frames: ticks=%0d intervals=%0d first=%0d want 1/1/2",
                     cnt_tick - t0, intervals.size(), (intervals.size() > 0) ? intervals[0] : -1);
        end
    endtask

    task automatic test_preempt();
        int c;
        int e0, s0, f0;
        e0 = cnt_eat;
        s0 = cnt_succ;
        f0 = cnt_fail;
        intervals.delete();
        request(4'b0010, c);
        wait_cycles(8);
        check_latency("preempt_succ", 4'b0100, 4'b0100);
        wait_cycles(8);
        request(4'b1000, c);
        wait_cycles(3);
        n_cmp++;
        if (cnt_fail - f0 !== 0) begin
            n_err++;
            $display("FAIL fail_no_preempt_succ: fail pulses %0d want 0", cnt_fail - f0);
        end
        wait_idle("preempt");
        n_cmp++;
        if (cnt_fail - f0 !== 1 || cnt_eat - e0 !== 1 || cnt_succ - s0 !== 1) begin
            n_err++;
            $display("FAIL preempt_counts: fail=%0d eat=%0d succ=%0d want 1/1/1",
                     cnt_fail - f0, cnt_eat - e0, cnt_succ - s0);
        end
        n_cmp++;
        if (intervals.size() !== 2 || intervals[1] !== 25) begin
            n_err++;
            $display("FAIL preempt_fail_after_succ: intervals=%0d last=%0d want 2/25",
                     intervals.size(), (intervals.size() > 1) ? intervals[1] : -1);
        end
    endtask

    task automatic test_simultaneous();
        int e0, s0, f0, t0;
        e0 = cnt_eat;
        s0 = cnt_succ;
        f0 = cnt_fail;
        t0 = cnt_tick;
        intervals.delete();
        check_latency("simultaneous", 4'b1111, 4'b1000);
        wait_idle("simultaneous");
        n_cmp++;
        if (cnt_fail - f0 !== 1 || cnt_succ - s0 !== 0 || cnt_eat - e0 !== 0 || cnt_tick - t0 !== 0) begin
            n_err++;
            $display("FAIL simultaneous_counts: fail=%0d succ=%0d eat=%0d tick=%0d want 1/0/0/0",
                     cnt_fail - f0, cnt_succ - s0, cnt_eat - e0, cnt_tick - t0);
        end
        n_cmp++;
        if (intervals.size() !== 1 || intervals[0] !== 25) begin
            n_err++;
            $display("FAIL simultaneous_frames: intervals=%0d first=%0d want 1/25",
                     intervals.size(), (intervals.size() > 0) ? intervals[0] : -1);
        end
    endtask

    task automatic test_mute();
        int c;
        int e0;
        e0 = cnt_eat;
        request(4'b0010, c);
        wait_cycles(6);
        request(4'b0010, c);
        request(4'b0010, c);
        wait_cycles(6);
        @(posedge clk);
        #1;
        mute = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL mute_busy_before: busy=%b want 1", busy);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL mute_busy_after: busy=%b want 0", busy);
        end
        request(4'b0010, c);
        wait_cycles(8);
        mute = 1'b0;
        wait_cycles(120);
        n_cmp++;
        if (cnt_eat - e0 !== 1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mute_cleared: eat pulses %0d busy=%b want 1/0", cnt_eat - e0, busy);
        end
        check_latency("after_mute", 4'b0010, 4'b0010);
        wait_idle("after_mute");
    endtask

    initial begin
        {failure, success, eat, tick} = 4'b0000;
        mute = 1'b0;
        rst = 1'b1;
        test_reset();
        wait_cycles(4);
        test_single_eat();
        test_four_eats();
        test_tick();
        test_preempt();
        test_simultaneous();
        test_mute();
        n_cmp++;
        if (onehot_err !== 0 || nobusy_err !== 0 || gap_err !== 0) begin
            n_err++;
            $display("FAIL pulse_rules: onehot=%0d nobusy=%0d gap=%0d want 0/0/0",
                     onehot_err, nobusy_err, gap_err);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
